// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with two-entry skid buffer
module pipe_stage_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // State encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_n;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_n;
    logic             in_fire;
    logic             out_fire;

    // Handshake strobes and outputs decode from registered state only.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and storage selection; flush outranks any handshake.
    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = NOP_VALUE;
            skid_n  = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_n  = in_data;
                        state_n = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_n = in_data;
                    end else if (in_fire) begin
                        skid_n  = in_data;
                        state_n = FULL;
                    end else if (out_fire) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_n  = skid_q;
                        state_n = ONE;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = NOP_VALUE;
                    skid_n  = NOP_VALUE;
                end
            endcase
        end
    end

    // State and payload registers with synchronous reset to the NOP payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int               W   = 37;
    localparam logic [W-1:0]     NOP = 37'h0A_5A5A_5A5A;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (out_data !== NOP) begin errors++; $display("FAIL reset_out_data got=%h exp=%h", out_data, NOP); end
    endtask

    task automatic test_stream();
        logic [W-1:0] a [3];
        a[0] = 37'h01_0000_00A1;
        a[1] = 37'h02_0000_00A2;
        a[2] = 37'h03_0000_00A3;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = a[i];
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== a[i]) begin errors++; $display("FAIL stream_data[%0d] got=%h/%0b exp=%h/1", i, out_data, out_valid, a[i]); end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain got=%0b/%0d exp=0/0", out_valid, occupancy); end
        checks++; if (out_data !== a[2]) begin errors++; $display("FAIL stream_empty_hold got=%h exp=%h", out_data, a[2]); end
    endtask

    task automatic test_stall();
        logic [W-1:0] b [4];
        b[0] = 37'h10_0000_00B1;
        b[1] = 37'h11_0000_00B2;
        b[2] = 37'h12_0000_00B3;
        b[3] = 37'h13_0000_00B4;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = b[0];
        step();
        checks++; if (out_data !== b[0] || occupancy !== 2'd1) begin errors++; $display("FAIL stall_b1 got=%h/%0d exp=%h/1", out_data, occupancy, b[0]); end
        out_ready = 1'b0;
        in_data   = b[1];
        step();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_full got=%0d/%0b exp=2/0", occupancy, in_ready); end
        checks++; if (out_data !== b[0] || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_b1 got=%h exp=%h", out_data, b[0]); end
        in_data = b[2];
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (occupancy !== 2'd2 || out_data !== b[0]) begin errors++; $display("FAIL stall_wait[%0d] got=%0d/%h exp=2/%h", i, occupancy, out_data, b[0]); end
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== b[1] || occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%h/%0d/%0b exp=%h/1/1", out_data, occupancy, in_ready, b[1]); end
        step();
        checks++; if (out_data !== b[2] || occupancy !== 2'd1) begin errors++; $display("FAIL stall_b3 got=%h/%0d exp=%h/1", out_data, occupancy, b[2]); end
        in_data = b[3];
        step();
        checks++; if (out_data !== b[3] || occupancy !== 2'd1) begin errors++; $display("FAIL stall_b4 got=%h/%0d exp=%h/1", out_data, occupancy, b[3]); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stall_drain got=%0b/%0d exp=0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush_full();
        logic [W-1:0] c3;
        c3 = 37'h1C_0000_00C3;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 37'h1C_0000_00C1;
        step();
        in_data   = 37'h1C_0000_00C2;
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill got=%0d exp=2", occupancy); end
        flush   = 1'b1;
        in_data = c3;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got=%0b/%0d/%0b exp=0/0/1", out_valid, occupancy, in_ready); end
        checks++; if (out_data !== NOP) begin errors++; $display("FAIL flush_data got=%h exp=%h", out_data, NOP); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0 || out_data === c3) begin errors++; $display("FAIL flush_c3_dropped[%0d] got=%0b/%h exp=0/%h", i, out_valid, out_data, NOP); end
        end
    endtask

    task automatic test_rst_flush();
        logic [W-1:0] d1;
        d1 = 37'h0D_0000_00D1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 37'h0E_0000_00E1;
        step();
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL rstflush_prefill got=%0d exp=1", occupancy); end
        rst     = 1'b1;
        flush   = 1'b1;
        in_data = 37'h0E_0000_00E2;
        step();
        rst   = 1'b0;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin errors++; $display("FAIL rstflush_state got=%0b/%0b/%0d exp=0/1/0", out_valid, in_ready, occupancy); end
        checks++; if (out_data !== NOP) begin errors++; $display("FAIL rstflush_data got=%h exp=%h", out_data, NOP); end
        in_data = d1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== d1 || occupancy !== 2'd1) begin errors++; $display("FAIL rstflush_d1 got=%0b/%h/%0d exp=1/%h/1", out_valid, out_data, occupancy, d1); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstflush_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [63:0]  r;
        int           delivered;
        delivered = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(1, 0) == 1);
            out_ready = ($urandom_range(1, 0) == 1);
            r = {$urandom(), $urandom()};
            in_data = r[W-1:0];
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0 || out_data !== q[0]) begin
                    errors++;
                    $display("FAIL rand_order cyc=%0d got=%h exp=%h", cyc, out_data, (q.size() == 0) ? '0 : q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                delivered++;
            end
            if (in_valid && in_ready) q.push_back(in_data);
            step();
            checks++;
            if (occupancy !== q.size() || in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_occ cyc=%0d got=%0d/%0b/%0b exp=%0d", cyc, occupancy, in_ready, out_valid, q.size());
            end
        end
        checks++; if (delivered < 100) begin errors++; $display("FAIL rand_activity got=%0d exp>=100", delivered); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush_full();
        test_rst_flush();
        test_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, reset- and flush-capable pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It replaces the free-running inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) so that any stage can stall or be flushed without losing or duplicating an instruction. The stage's payload fields are concatenated into a single `WIDTH`-bit bus.

## Interface
- `WIDTH`, default 64: payload width in bits. The IF/ID case is PC plus INSTR, which is 64.
- `NOP_VALUE`, default `{WIDTH{1'b0}}`: payload value loaded on reset and on flush.

Ports:
- `clk`  input  1: stage clock. All state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `flush`  input  1: synchronous discard of all held entries (branch mispredict or exception).
- `in_valid`  input  1: upstream presents a beat.
- `in_ready`  output  1: the stage can accept a beat.
- `in_data`  input  WIDTH: upstream payload.
- `out_valid`  output  1: the stage presents a beat.
- `out_ready`  input  1: downstream accepts a beat.
- `out_data`  output  WIDTH: downstream payload.
- `occupancy`  output  2: number of held entries, 0 to 2.

## Operation
- Handshake events:
  - `in_fire` = `in_valid & in_ready`.
  - `out_fire` = `out_valid & out_ready`.
- Storage:
  - `main` register drives `out_data`.
  - `skid` register catches the beat accepted in the same cycle that downstream stalls.
- State machine:
  - EMPTY: occupancy 0.
  - ONE: occupancy 1.
  - FULL: occupancy 2.
- Transitions from EMPTY:
  - `in_fire`: main <= in_data, go to ONE.
  - Otherwise: stay in EMPTY.
- Transitions from ONE:
  - `in_fire & out_fire`: main <= in_data, stay in ONE.
  - `in_fire & !out_fire`: skid <= in_data, go to FULL.
  - `!in_fire & out_fire`: go to EMPTY.
  - Neither: hold.
- Transitions from FULL:
  - `out_fire`: main <= skid, go to ONE.
  - Otherwise: hold.
  - `in_ready` is 0, so no input can be accepted in FULL.
- Output decode:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
  - `occupancy` = state encoding.
  - All three decode from state registers only; there is no combinational path from `in_valid` or `out_ready` to any output.
- Empty-stage data: in EMPTY, `out_data` keeps the last value held in main (NOP_VALUE after reset or flush). Consumers must qualify it with `out_valid`.
- Priority: `rst` > `flush` > handshake.
- Flush:
  - Next state is EMPTY, and main and skid load NOP_VALUE.
  - An `in_fire` in the flush cycle is dropped. An `out_fire` in the flush cycle still completes; the beat is considered consumed.
- Invariant: beats leave in acceptance order, with no loss and no duplication.

## Timing
- Values after the reset edge:
  - `out_valid` = 0.
  - `in_ready` = 1.
  - `occupancy` = 0.
  - `out_data` = NOP_VALUE.
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N, i.e. in cycle N+1. That is one cycle, matching the plain latch it replaces.
- Throughput: 1 beat per cycle while `out_ready` is held at 1. Occupancy stays at 0 or 1 in this mode, and the skid is never used.
- Downstream stall: when `out_ready` drops, one more beat is absorbed (ONE to FULL). `in_ready` falls on the following cycle.
- Stall release: releasing `out_ready` in FULL drains skid into main on that edge. `in_ready` returns to 1 in the next cycle.
- Back-to-back: a simultaneous `in_fire` and `out_fire` in ONE replaces main with no bubble.
- Flush takes effect at the next edge. `out_valid` = 0 and `in_ready` = 1 in the following cycle, regardless of the prior state.
- Mid-operation reset behaves exactly as flush and also overrides a concurrent flush or handshake.

## Test plan
- Reset, then stream A1, A2, A3 with `in_valid` = 1 and `out_ready` = 1:
  - `out_data` shows A1, A2, A3 on consecutive cycles, each one cycle after acceptance.
  - `occupancy` never exceeds 1.
- Stream beats B1 to B4, and drop `out_ready` for 3 cycles after B1 is presented:
  - B2 is absorbed into skid, `occupancy` = 2 and `in_ready` = 0.
  - On release, the output order is B1, B2, B3, B4 with no duplicate and no gap.
- In FULL (holding C1 in main, C2 in skid), assert `flush` together with `in_valid` carrying C3:
  - Next cycle: `out_valid` = 0, `occupancy` = 0, `out_data` = NOP_VALUE, `in_ready` = 1.
  - C3 never appears.
- In ONE, assert `rst` and `flush` together with `in_fire`:
  - The outcome equals the reset values.
  - A subsequent beat D1 appears one cycle after its acceptance.
- Random `in_valid` and `out_ready` at 50% each, over 10 000 cycles with `WIDTH` = 37:
  - The scoreboard shows in-order, lossless delivery.
  - `in_ready` = 0 only when `occupancy` = 2.
  - `occupancy` equals accepted beats minus delivered beats.
